// File: rtl/cmp_branch_unit_pkg.sv
// Shared ALU definitions: branch/compare opcodes and the sign-flip constant
// that lets a single unsigned comparator serve signed compares.
package cmp_branch_unit_pkg;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'd0,
        OP_BNE  = 3'd1,
        OP_BLEZ = 3'd2,
        OP_BGTZ = 3'd3,
        OP_BLTZ = 3'd4,
        OP_BGEZ = 3'd5,
        OP_SLT  = 3'd6,
        OP_SLTU = 3'd7
    } op_e;

    // XOR with this maps two's-complement ordering onto unsigned ordering.
    localparam logic [31:0] SIGN_FLIP = 32'h8000_0000;

    // Single-operand branches compare A against zero.
    function automatic logic is_zero_cmp(input op_e op);
        return (op == OP_BLEZ) || (op == OP_BGTZ) || (op == OP_BLTZ) || (op == OP_BGEZ);
    endfunction

    // Everything except SLTU is a signed comparison.
    function automatic logic is_signed_cmp(input op_e op);
        return (op != OP_SLTU);
    endfunction

endpackage

// File: rtl/cmp_branch_unit_comparator.sv
// Plain 32-bit unsigned magnitude comparator producing gt/eq/lt flags.
module comparator_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        gt,
    output logic        eq,
    output logic        lt
);

    // Exactly one of the three flags is set for any operand pair.
    always_comb begin
        gt = (a > b);
        eq = (a == b);
        lt = (a < b);
    end

endmodule

// File: rtl/cmp_branch_unit.sv
// Two-stage branch/compare unit: S1 captures operands, the compare runs on S1
// contents and its decision is registered into S2, which drives the outputs.
module cmp_branch_unit
    import cmp_branch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_target,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_taken,
    output logic [31:0] out_result,
    output logic [31:0] out_target
);

    // Stage 1: operands
    logic        s1_valid;
    op_e         s1_op;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    logic [31:0] s1_target;

    // Stage 2: decision
    logic        s2_valid;
    logic        s2_taken;
    logic [31:0] s2_result;
    logic [31:0] s2_target;

    logic        accept;
    logic        s2_load;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic        cmp_gt;
    logic        cmp_eq;
    logic        cmp_lt;
    logic        dec_taken;
    logic [31:0] dec_result;

    // S2 can take a new entry when it is empty or its result leaves this cycle.
    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = !flush && (!s1_valid || !s2_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Operand conditioning: zero B for single-operand branches, sign-flip for signed ops.
    always_comb begin
        cmp_a = s1_a;
        cmp_b = is_zero_cmp(s1_op) ? 32'h0 : s1_b;
        if (is_signed_cmp(s1_op)) begin
            cmp_a = cmp_a ^ SIGN_FLIP;
            cmp_b = cmp_b ^ SIGN_FLIP;
        end
    end

    comparator_32 u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    // Map comparator flags to the per-opcode decision.
    always_comb begin
        dec_taken  = 1'b0;
        dec_result = 32'h0;
        case (s1_op)
            OP_BEQ:  dec_taken = cmp_eq;
            OP_BNE:  dec_taken = !cmp_eq;
            OP_BLEZ: dec_taken = cmp_lt || cmp_eq;
            OP_BGTZ: dec_taken = cmp_gt;
            OP_BLTZ: dec_taken = cmp_lt;
            OP_BGEZ: dec_taken = cmp_gt || cmp_eq;
            OP_SLT,
            OP_SLTU: dec_result = {31'b0, cmp_lt};
            default: dec_taken = 1'b0;
        endcase
    end

    // S1 occupancy: filled on accept, emptied when it moves into S2; flush wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
        end else if (s2_load) begin
            s1_valid <= 1'b0;
        end
    end

    // S1 operand capture; these registers need no reset since s1_valid qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op     <= op_e'(in_op);
            s1_a      <= in_a;
            s1_b      <= in_b;
            s1_target <= in_target;
        end
    end

    // S2 decision register; reset so the outputs read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_taken  <= 1'b0;
            s2_result <= 32'h0;
            s2_target <= 32'h0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_taken  <= dec_taken;
                s2_result <= dec_result;
                s2_target <= s1_target;
            end
        end
    end

    assign out_valid  = s2_valid;
    assign out_taken  = s2_taken;
    assign out_result = s2_result;
    assign out_target = s2_target;

endmodule

// File: tb/tb_cmp_branch_unit.sv
// Directed bench for cmp_branch_unit: a vector table of single operations plus
// hand-written stall, flush and reset sequences. Inputs change and outputs are
// sampled on the falling edge.
module tb_cmp_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_target;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic        out_taken;
    logic [31:0] out_result;
    logic [31:0] out_target;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmp_branch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_target  (in_target),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_taken  (out_taken),
        .out_result (out_result),
        .out_target (out_target)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] target;
        logic        taken;
        logic [31:0] result;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] target, logic taken, logic [31:0] result);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.target = target; v.taken = taken; v.result = result;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] target);
        in_valid  = 1'b1;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_target = target;
    endtask

    task automatic check_out(input string name, input logic taken, input logic [31:0] result,
                             input logic [31:0] target);
        check({name, ".valid"},  {31'b0, out_valid}, 32'h1);
        check({name, ".taken"},  {31'b0, out_taken}, {31'b0, taken});
        check({name, ".result"}, out_result, result);
        check({name, ".target"}, out_target, target);
    endtask

    initial begin
        // Opcodes: 0 BEQ 1 BNE 2 BLEZ 3 BGTZ 4 BLTZ 5 BGEZ 6 SLT 7 SLTU
        vecs.push_back(mk("beq_eq",        3'd0, 32'h1234ABCD, 32'h1234ABCD, 32'h0000_1000, 1'b1, 32'h0));
        vecs.push_back(mk("beq_ne",        3'd0, 32'h0000_0001, 32'h0000_0002, 32'h0000_1004, 1'b0, 32'h0));
        vecs.push_back(mk("bne_eq",        3'd1, 32'h0000_0005, 32'h0000_0005, 32'h0000_1008, 1'b0, 32'h0));
        vecs.push_back(mk("bne_ne",        3'd1, 32'h0000_0005, 32'h0000_0006, 32'h0000_100C, 1'b1, 32'h0));
        vecs.push_back(mk("blez_zero",     3'd2, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0000_2000, 1'b1, 32'h0));
        vecs.push_back(mk("blez_pos_bign", 3'd2, 32'h0000_0003, 32'h0000_0005, 32'h0000_2004, 1'b0, 32'h0));
        vecs.push_back(mk("bgtz_zero",     3'd3, 32'h0000_0000, 32'h0000_0000, 32'h0000_2008, 1'b0, 32'h0));
        vecs.push_back(mk("bgtz_pos_bign", 3'd3, 32'h0000_0001, 32'h0000_0005, 32'h0000_200C, 1'b1, 32'h0));
        vecs.push_back(mk("bltz_m1",       3'd4, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_3000, 1'b1, 32'h0));
        vecs.push_back(mk("bltz_minint",   3'd4, 32'h8000_0000, 32'h0000_0000, 32'h0000_3004, 1'b1, 32'h0));
        vecs.push_back(mk("bgez_m1",       3'd5, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_3008, 1'b0, 32'h0));
        vecs.push_back(mk("bgez_zero",     3'd5, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_300C, 1'b1, 32'h0));
        vecs.push_back(mk("slt_extreme",   3'd6, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_4000, 1'b0, 32'h1));
        vecs.push_back(mk("sltu_extreme",  3'd7, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_4004, 1'b0, 32'h0));
        vecs.push_back(mk("slt_equal",     3'd6, 32'h0000_0005, 32'h0000_0005, 32'h0000_4008, 1'b0, 32'h0));
        vecs.push_back(mk("slt_m1_1",      3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_400C, 1'b0, 32'h1));
        vecs.push_back(mk("sltu_1_max",    3'd7, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_4010, 1'b0, 32'h1));
        vecs.push_back(mk("sltu_max_1",    3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_4014, 1'b0, 32'h0));

        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0; in_target = '0;
        flush = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.out_valid",  {31'b0, out_valid}, 32'h0);
        check("rst.out_taken",  {31'b0, out_taken}, 32'h0);
        check("rst.out_result", out_result, 32'h0);
        check("rst.out_target", out_target, 32'h0);
        rst = 1'b0;
        #1;
        check("rst.in_ready_after", {31'b0, in_ready}, 32'h1);

        // Table: one operation at a time, two-cycle latency check on each
        foreach (vecs[i]) begin
            @(negedge clk);
            drive_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].target);
            #1;
            check({vecs[i].name, ".in_ready"}, {31'b0, in_ready}, 32'h1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            check({vecs[i].name, ".valid_c1"}, {31'b0, out_valid}, 32'h0);
            @(negedge clk);
            check_out(vecs[i].name, vecs[i].taken, vecs[i].result, vecs[i].target);
            $display("vec %s op=%0d a=%h b=%h -> taken=%0d result=%h target=%h",
                     vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, out_taken, out_result, out_target);
        end
        @(negedge clk);
        check("idle.out_valid", {31'b0, out_valid}, 32'h0);

        // Stall: three ops with out_ready low, then release and drain in order
        out_ready = 1'b0;
        drive_op(3'd0, 32'h7, 32'h7, 32'h100);              // A: BEQ taken
        @(negedge clk);
        drive_op(3'd6, 32'h8000_0000, 32'h1, 32'h200);      // B: SLT -> 1
        #1 check("stall.in_ready_b", {31'b0, in_ready}, 32'h1);
        @(negedge clk);
        drive_op(3'd3, 32'h0, 32'h0, 32'h300);              // C: BGTZ 0 -> not taken
        #1 check("stall.in_ready_full", {31'b0, in_ready}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            check_out("stall.hold_a", 1'b1, 32'h0, 32'h100);
            check("stall.in_ready_hold", {31'b0, in_ready}, 32'h0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("stall.in_ready_release", {31'b0, in_ready}, 32'h1);
        check_out("drain.a", 1'b1, 32'h0, 32'h100);
        $display("drain A target=%h", out_target);
        @(negedge clk);
        in_valid = 1'b0;
        check_out("drain.b", 1'b0, 32'h1, 32'h200);
        $display("drain B target=%h", out_target);
        @(negedge clk);
        check_out("drain.c", 1'b0, 32'h0, 32'h300);
        $display("drain C target=%h", out_target);
        @(negedge clk);
        check("drain.empty", {31'b0, out_valid}, 32'h0);

        // Flush after two back-to-back accepts: neither result is presented afterwards
        out_ready = 1'b0;
        drive_op(3'd0, 32'h1, 32'h1, 32'h500);
        @(negedge clk);
        drive_op(3'd1, 32'h1, 32'h2, 32'h600);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        #1 check("flush.in_ready", {31'b0, in_ready}, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        check("flush.out_valid", {31'b0, out_valid}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("flush.never", {31'b0, out_valid}, 32'h0);
        end
        $display("flush sequence done");

        // Asynchronous reset mid-stream
        drive_op(3'd0, 32'h9, 32'h9, 32'h700);
        @(negedge clk);
        drive_op(3'd5, 32'h1, 32'h0, 32'h800);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("arst.out_valid_now", {31'b0, out_valid}, 32'h0);
        check("arst.out_target_now", out_target, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 check("arst.in_ready_after", {31'b0, in_ready}, 32'h1);
        check("arst.taken",  {31'b0, out_taken}, 32'h0);
        check("arst.result", out_result, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("arst.discarded", {31'b0, out_valid}, 32'h0);
        end
        $display("async reset sequence done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
